result_serializer: RTL and testbench

//  Downstream stage of the threshold filter. Captures each PIXEL_NUM-wide result

---
 rtl/result_serializer.sv | 65 ++++++
 tb/tb_result_serializer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// result_serializer: captures filter result vectors into a small FIFO and streams
// them out one pixel per cycle, highest pixel index first.
module result_serializer #(
    parameter int PIXEL_SIZE = 3,
    parameter int PIXEL_NUM  = 3,
    parameter int DEPTH      = 4
) (
    input  logic                                     clk,
    input  logic                                     areset,
    input  logic                                     in_valid,
    input  logic [PIXEL_NUM-1:0][(2**PIXEL_SIZE)-1:0] in_vec,
    input  logic                                     flush,
    output logic [(2**PIXEL_SIZE)-1:0]               out_data,
    output logic                                     out_valid,
    output logic                                     out_last,
    input  logic                                     out_ready,
    output logic [$clog2(DEPTH+1)-1:0]               count,
    output logic                                     full,
    output logic                                     overflow
);
    localparam int PW = 2**PIXEL_SIZE;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = PIXEL_NUM > 1 ? $clog2(PIXEL_NUM) : 1;
    localparam logic [IW-1:0] LAST = IW'(PIXEL_NUM-1);

    logic [PIXEL_NUM-1:0][PW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] idx;
    logic wr, xfer, pop;

    // a full FIFO rejects even when a pop happens on the same edge
    assign full      = count == CW'(DEPTH);
    assign wr        = in_valid && !full && !flush;
    assign out_valid = count != '0;
    assign out_last  = out_valid && idx == LAST;
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && idx == LAST;
    assign out_data  = out_valid ? mem[rd_ptr][LAST - idx] : '0;

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= in_vec;

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (xfer) idx <= pop ? '0 : idx + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr) - CW'(pop);
            if (in_valid && full) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed checks of the result serializer with default parameters.
module tb_result_serializer;
    logic            clk = 1'b0;
    logic            areset = 1'b0;
    logic            in_valid = 1'b0;
    logic [2:0][7:0] in_vec = '0;
    logic            flush = 1'b0;
    logic [7:0]      out_data;
    logic            out_valid, out_last;
    logic            out_ready = 1'b0;
    logic [2:0]      count;
    logic            full, overflow;
    int tests = 0;
    int fails = 0;

    result_serializer dut (
        .clk(clk), .areset(areset), .in_valid(in_valid), .in_vec(in_vec), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0][7:0] mk(input logic [7:0] a0, a1, a2);
        logic [2:0][7:0] v;
        v[0] = a0;
        v[1] = a1;
        v[2] = a2;
        return v;
    endfunction

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        tick();
        tick();
        areset = 1'b1;
        tick();
        chk("idle_valid", 32'(out_valid), 0);

        // single vector, free-running consumer
        in_vec = mk(8'd5, 8'd4, 8'd3);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t2_count", 32'(count), 1);
        chk("t2_d0", 32'(out_data), 3);
        chk("t2_l0", 32'(out_last), 0);
        tick();
        chk("t2_d1", 32'(out_data), 4);
        chk("t2_l1", 32'(out_last), 0);
        tick();
        chk("t2_d2", 32'(out_data), 5);
        chk("t2_l2", 32'(out_last), 1);
        tick();
        chk("t2_count_end", 32'(count), 0);
        chk("t2_valid_end", 32'(out_valid), 0);
        chk("t2_data_end", 32'(out_data), 0);

        // backpressure holds the first pixel
        out_ready = 1'b0;
        in_vec = mk(8'd9, 8'd8, 8'd7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_d", 32'(out_data), 7);
            chk("t3_hold_l", 32'(out_last), 0);
            tick();
        end
        out_ready = 1'b1;
        chk("t3_d0", 32'(out_data), 7);
        tick();
        chk("t3_d1", 32'(out_data), 8);
        tick();
        chk("t3_d2", 32'(out_data), 9);
        chk("t3_l2", 32'(out_last), 1);
        tick();
        chk("t3_empty", 32'(out_valid), 0);

        // overflow: five vectors into a four-deep FIFO
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_vec = mk(8'(16*k), 8'(16*k+1), 8'(16*k+2));
            tick();
            if (k == 3) begin
                chk("t4_full4", 32'(full), 1);
                chk("t4_ovf4", 32'(overflow), 0);
            end
        end
        in_valid = 1'b0;
        chk("t4_count", 32'(count), 4);
        chk("t4_full", 32'(full), 1);
        chk("t4_ovf", 32'(overflow), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int j = 2; j >= 0; j--) begin
                chk("t4_drain_d", 32'(out_data), 32'(16*k+j));
                chk("t4_drain_l", 32'(out_last), 32'(j == 0));
                tick();
            end
        chk("t4_empty", 32'(out_valid), 0);
        chk("t4_ovf_sticky", 32'(overflow), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_ovf_flushed", 32'(overflow), 0);

        // concurrent pop and push on the same edge
        in_vec = mk(8'h21, 8'h22, 8'h23);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_a0", 32'(out_data), 32'h23);
        tick();
        tick();
        chk("t5_a2", 32'(out_data), 32'h21);
        chk("t5_a2_last", 32'(out_last), 1);
        in_vec = mk(8'h31, 8'h32, 8'h33);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_count", 32'(count), 1);
        chk("t5_b0", 32'(out_data), 32'h33);
        tick();
        tick();
        chk("t5_b2", 32'(out_data), 32'h31);
        tick();
        chk("t5_empty", 32'(count), 0);

        // flush overrides a simultaneous write
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_vec = mk(8'(k), 8'(k), 8'(k));
            tick();
        end
        chk("t6_count3", 32'(count), 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t6_count", 32'(count), 0);
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_ovf", 32'(overflow), 0);

        // asynchronous reset mid-drain with overflow set
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_vec = mk(8'h40, 8'h41, 8'h42);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (7) tick();
        out_ready = 1'b0;
        chk("t1_count2", 32'(count), 2);
        chk("t1_idx1", 32'(out_data), 32'h41);
        chk("t1_ovf_pre", 32'(overflow), 1);
        #2;
        areset = 1'b0;
        #1;
        chk("t1_valid", 32'(out_valid), 0);
        chk("t1_count", 32'(count), 0);
        chk("t1_ovf", 32'(overflow), 0);
        chk("t1_data", 32'(out_data), 0);
        chk("t1_last", 32'(out_last), 0);
        tick();
        areset = 1'b1;
        tick();
        tick();
        chk("t1_idle", 32'(out_valid), 0);
        in_vec = mk(8'h55, 8'h66, 8'h77);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_resume", 32'(out_data), 32'h77);
        chk("t1_resume_cnt", 32'(count), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
